bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 147 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
//
// A conversion is accepted from IDLE on a clock edge with start=1. It then
// performs BIN_W shift steps and one load step. The registered result appears
// with a one-cycle valid pulse BIN_W+1 clocks after the accepting edge.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     conversion request, honoured only while ready=1
//   bin_in    unsigned binary operand, captured on the accepting edge
//   ready     high in IDLE: a start will be accepted
//   valid     one-cycle pulse, a new result is on bcd_out/blank/overflow
//   bcd_out   packed BCD result, digit 0 in [3:0]
//   blank     leading-zero mask, bit i=1 when digit i is a leading zero
//   overflow  operand was >= 10^DIGITS; bcd_out holds the low DIGITS digits
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  ready,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow
);

  localparam int unsigned CntW  = $clog2(BIN_W + 1);
  localparam int unsigned WorkW = 4 * DIGITS;
  // Every digit except digit 0 is a leading zero of the all-zero value.
  localparam logic [DIGITS-1:0] BlankRst = {DIGITS{1'b1}} << 1;

  typedef enum logic [1:0] {StIdle, StShift, StLoad} state_e;

  state_e              state_q, state_d;
  logic [WorkW-1:0]    work_q, work_d;
  logic [BIN_W-1:0]    shift_q, shift_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [WorkW-1:0]    bcd_q, bcd_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                ovf_out_q, ovf_out_d;
  logic                valid_q, valid_d;

  logic [WorkW-1:0]    work_adj;
  logic [DIGITS-1:0]   blank_calc;
  logic                upper_zero;

  // Add-3 correction applied to every digit before the shift.
  always_comb begin
    work_adj = work_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero mask of the finished work register; digit 0 is never blanked.
  always_comb begin
    blank_calc = '0;
    upper_zero = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      upper_zero    = upper_zero & (work_q[4*i +: 4] == 4'd0);
      blank_calc[i] = upper_zero;
    end
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    bcd_d     = bcd_q;
    blank_d   = blank_q;
    ovf_out_d = ovf_out_q;
    valid_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          shift_d = bin_in;
          work_d  = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        work_d  = {work_adj[WorkW-2:0], shift_q[BIN_W-1]};
        shift_d = {shift_q[BIN_W-2:0], 1'b0};
        // A bit leaving the top digit means the value does not fit.
        ovf_d   = ovf_q | work_adj[WorkW-1];
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(BIN_W - 1)) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        bcd_d     = work_q;
        blank_d   = blank_calc;
        ovf_out_d = ovf_q;
        valid_d   = 1'b1;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      work_q    <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
      blank_q   <= BlankRst;
      ovf_out_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      bcd_q     <= bcd_d;
      blank_q   <= blank_d;
      ovf_out_q <= ovf_out_d;
      valid_q   <= valid_d;
    end
  end

  assign ready    = (state_q == StIdle);
  assign valid    = valid_q;
  assign bcd_out  = bcd_q;
  assign blank    = blank_q;
  assign overflow = ovf_out_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: a 5-digit and a 4-digit instance share clock, reset,
// start and bin_in; results are compared with an arithmetic decimal model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] bin_in;

  logic        ready5, valid5, ovf5;
  logic [19:0] bcd5;
  logic [4:0]  blank5;
  logic        ready4, valid4, ovf4;
  logic [15:0] bcd4;
  logic [3:0]  blank4;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_dut5 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin_in   (bin_in),
    .ready    (ready5),
    .valid    (valid5),
    .bcd_out  (bcd5),
    .blank    (blank5),
    .overflow (ovf5)
  );

  bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin_in   (bin_in),
    .ready    (ready4),
    .valid    (valid4),
    .bcd_out  (bcd4),
    .blank    (blank4),
    .overflow (ovf4)
  );

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r = 1;
    for (int i = 0; i < int'(n); i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [19:0] model_bcd(input int unsigned v, input int unsigned d);
    int unsigned m = v % pow10(d);
    logic [19:0] r = '0;
    for (int i = 0; i < int'(d); i++) r[4*i +: 4] = 4'((m / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [4:0] model_blank(input int unsigned v, input int unsigned d);
    int unsigned m = v % pow10(d);
    logic [4:0] r = '0;
    for (int i = 1; i < int'(d); i++) r[i] = ((m / pow10(i)) == 0);
    return r;
  endfunction

  function automatic logic model_ovf(input int unsigned v, input int unsigned d);
    return v >= pow10(d);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_results(input int unsigned v);
    check("bcd5", 32'(bcd5), 32'(model_bcd(v, 5)));
    check("blank5", 32'(blank5), 32'(model_blank(v, 5)));
    check("ovf5", 32'(ovf5), 32'(model_ovf(v, 5)));
    check("bcd4", 32'(bcd4), 32'(model_bcd(v, 4) & 20'h0FFFF));
    check("blank4", 32'(blank4), 32'(model_blank(v, 4) & 5'h0F));
    check("ovf4", 32'(ovf4), 32'(model_ovf(v, 4)));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 32'(ready5), 32'd1);
    check({tag, "_valid"}, 32'({valid5, valid4}), 32'd0);
    check({tag, "_bcd5"}, 32'(bcd5), 32'd0);
    check({tag, "_blank5"}, 32'(blank5), 32'b11110);
    check({tag, "_blank4"}, 32'(blank4), 32'b1110);
    check({tag, "_ovf"}, 32'({ovf5, ovf4}), 32'd0);
  endtask

  // Called at a falling edge: requests a conversion of v, disturbs start and
  // bin_in while busy, then checks latency, result and the idle hold period.
  task automatic convert(input logic [15:0] v);
    int k;
    int extra;
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 16'($urandom);
    check("ready_busy", 32'({ready5, ready4}), 32'd0);
    k = 0;
    while (!valid5 && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 5) begin
        start  = 1'b1;
        bin_in = 16'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    check("latency", 32'(k), 32'd17);
    check("valid4", 32'(valid4), 32'd1);
    check_results(32'(v));
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid5 || valid4) extra++;
    end
    check("extra_valid", 32'(extra), 32'd0);
    check("hold_bcd5", 32'(bcd5), 32'(model_bcd(32'(v), 5)));
    check("ready_idle", 32'({ready5, ready4}), 32'd3);
  endtask

  initial begin
    int cyc;
    int nval;
    int vcyc[3];
    logic [19:0] vbcd[3];
    bit bump;

    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    repeat (2) @(negedge clk);
    check_reset_state("rst");
    rst_n = 1'b1;
    @(negedge clk);

    convert(16'h270F);
    convert(16'hFFFF);
    convert(16'd0);
    convert(16'd12345);
    convert(16'd9999);
    convert(16'd10000);
    convert(16'd42);
    for (int n = 0; n < 20; n++) convert(16'($urandom));

    // Reset at clock 8 of a conversion aborts it.
    start  = 1'b1;
    bin_in = 16'd1234;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    cyc = 0;
    repeat (3) begin
      @(negedge clk);
      if (valid5 || valid4) cyc++;
    end
    check("midrst_novalid", 32'(cyc), 32'd0);
    // Start coincides with release: accepted on the first edge.
    rst_n = 1'b1;
    convert(16'd100);

    // Back-to-back with start held high.
    start  = 1'b1;
    bin_in = 16'd1;
    nval   = 0;
    bump   = 1'b0;
    cyc    = 0;
    vcyc   = '{0, 0, 0};
    vbcd   = '{20'h0, 20'h0, 20'h0};
    while (nval < 3 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bin_in = 16'd2;
      end else if (bump) begin
        bin_in = bin_in + 16'd1;
        bump   = 1'b0;
      end
      if (valid5) begin
        vcyc[nval] = cyc;
        vbcd[nval] = bcd5;
        nval++;
        bump = 1'b1;
        if (nval == 3) start = 1'b0;
      end
    end
    check("b2b_count", 32'(nval), 32'd3);
    check("b2b_first", 32'(vcyc[0]), 32'd18);
    check("b2b_gap1", 32'(vcyc[1] - vcyc[0]), 32'd18);
    check("b2b_gap2", 32'(vcyc[2] - vcyc[1]), 32'd18);
    check("b2b_val1", 32'(vbcd[0]), 32'(model_bcd(1, 5)));
    check("b2b_val2", 32'(vbcd[1]), 32'(model_bcd(2, 5)));
    check("b2b_val3", 32'(vbcd[2]), 32'(model_bcd(3, 5)));
    repeat (20) @(negedge clk);
    check("b2b_idle", 32'(ready5), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
